// File: rtl/axis_pattern_gen.sv
// Multi-channel AXI4-Stream test-pattern source: counter, LFSR, constant and
// walking-ones data, round-robin tdest, byte-accurate packet length, gaps and stop.
module axis_pattern_gen #(
  parameter  int DATA_W = 32,
  parameter  int N_CH   = 4,
  parameter  int LEN_W  = 16,
  localparam int LANES  = DATA_W / 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int DEST_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        cfg_mode,
  input  logic [LEN_W-1:0]  cfg_pkt_bytes,
  input  logic [31:0]       cfg_num_pkts,
  input  logic [7:0]        cfg_gap,
  input  logic [31:0]       cfg_const,
  output logic [DATA_W-1:0] tdata,
  output logic [BYTES-1:0]  tkeep,
  output logic              tlast,
  output logic [DEST_W-1:0] tdest,
  output logic              tvalid,
  input  logic              tready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pkts_sent
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_mode;
  logic [31:0]         r_const;
  logic [31:0]         r_num_pkts;
  logic [7:0]          r_gap;
  logic [7:0]          r_gap_cnt;
  logic [LEN_W-1:0]    r_beats;
  logic [LEN_W-1:0]    r_beat_idx;
  logic [BYTES-1:0]    r_last_keep;
  logic [DEST_W-1:0]   r_ch;
  logic                r_stop_pend;
  logic [31:0]         r_pkts_sent;
  logic                r_tvalid, r_tlast, r_busy, r_done;
  logic [DATA_W-1:0]   r_tdata;
  logic [BYTES-1:0]    r_tkeep;
  logic [DEST_W-1:0]   r_tdest;
  logic [23:0]         r_wcnt [N_CH];
  logic [31:0]         r_lfsr [N_CH];

  logic                w_hs, w_last_hs, w_limit, w_stop_any;
  logic                w_load, w_first, w_init, w_tvalid_nxt, w_done_nxt, w_gap_load;
  logic [LEN_W-1:0]    w_cfg_bytes, w_cfg_beats, w_rem;
  logic [BYTES-1:0]    w_cfg_keep, w_keep_sel;
  logic [LEN_W-1:0]    w_beats_sel, w_idx_nxt;
  logic                w_last_nxt;
  logic [DEST_W-1:0]   w_nch, w_src_ch;
  logic [23:0]         w_cur_w, w_nch_w, w_adv_w, w_src_w;
  logic [31:0]         w_cur_lfsr, w_nch_lfsr, w_adv_lfsr, w_src_lfsr;
  logic [1:0]          w_src_mode;
  logic [31:0]         w_src_const;
  logic [DATA_W-1:0]   w_beat_data;

  // Galois form of x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] gen_beat(input logic [1:0]        mode,
                                                 input logic [31:0]       cst,
                                                 input logic [DEST_W-1:0] ch,
                                                 input logic [23:0]       w,
                                                 input logic [31:0]       lfsr);
    logic [DATA_W-1:0] d;
    logic [31:0]       s;
    logic [23:0]       wi;
    d = '0;
    s = lfsr;
    for (int i = 0; i < LANES; i++) begin
      wi = w + 24'(i);
      s  = lfsr_step(s);
      case (mode)
        2'd0:    d[32*i +: 32] = {8'(ch), wi};
        2'd1:    d[32*i +: 32] = s;
        2'd2:    d[32*i +: 32] = cst;
        default: d[32*i +: 32] = 32'h1 << wi[4:0];
      endcase
    end
    return d;
  endfunction

  assign w_hs       = r_tvalid & tready;
  assign w_last_hs  = w_hs & r_tlast;
  assign w_limit    = (r_num_pkts != 32'd0) && ((r_pkts_sent + 32'd1) == r_num_pkts);
  assign w_stop_any = r_stop_pend | stop;

  assign w_cfg_bytes = (cfg_pkt_bytes == '0) ? LEN_W'(1) : cfg_pkt_bytes;
  assign w_rem       = w_cfg_bytes % LEN_W'(BYTES);
  assign w_cfg_beats = (w_cfg_bytes / LEN_W'(BYTES)) + {{(LEN_W-1){1'b0}}, (w_rem != '0)};

  always_comb begin
    w_cfg_keep = '0;
    for (int b = 0; b < BYTES; b++) w_cfg_keep[b] = (w_rem == '0) || (LEN_W'(b) < w_rem);
  end

  assign w_nch = (r_ch == DEST_W'(N_CH - 1)) ? '0 : r_ch + 1'b1;

  always_comb begin
    w_cur_w = '0; w_cur_lfsr = '0; w_nch_w = '0; w_nch_lfsr = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (c == int'(r_ch)) begin
        w_cur_w    = r_wcnt[c];
        w_cur_lfsr = r_lfsr[c];
      end
      if (c == int'(w_nch)) begin
        w_nch_w    = r_wcnt[c];
        w_nch_lfsr = r_lfsr[c];
      end
    end
  end

  always_comb begin
    w_adv_lfsr = w_cur_lfsr;
    for (int j = 0; j < LANES; j++) w_adv_lfsr = lfsr_step(w_adv_lfsr);
  end
  assign w_adv_w = w_cur_w + 24'(LANES);

  // Which channel state feeds the beat about to be loaded into the output register
  always_comb begin
    w_src_ch    = r_ch;
    w_src_w     = w_cur_w;
    w_src_lfsr  = w_cur_lfsr;
    w_src_mode  = r_mode;
    w_src_const = r_const;
    if (r_state == ST_IDLE) begin
      w_src_ch    = '0;
      w_src_w     = '0;
      w_src_lfsr  = 32'h1;
      w_src_mode  = cfg_mode;
      w_src_const = cfg_const;
    end else if (r_state == ST_SEND) begin
      if (!r_tlast) begin
        w_src_w    = w_adv_w;
        w_src_lfsr = w_adv_lfsr;
      end else begin
        w_src_ch   = w_nch;
        w_src_w    = (w_nch == r_ch) ? w_adv_w    : w_nch_w;
        w_src_lfsr = (w_nch == r_ch) ? w_adv_lfsr : w_nch_lfsr;
      end
    end
  end

  assign w_beat_data = gen_beat(w_src_mode, w_src_const, w_src_ch, w_src_w, w_src_lfsr);
  assign w_beats_sel = (r_state == ST_IDLE) ? w_cfg_beats : r_beats;
  assign w_keep_sel  = (r_state == ST_IDLE) ? w_cfg_keep  : r_last_keep;
  assign w_idx_nxt   = w_first ? '0 : r_beat_idx + 1'b1;
  assign w_last_nxt  = (w_idx_nxt == w_beats_sel - 1'b1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_first      = 1'b0;
    w_init       = 1'b0;
    w_tvalid_nxt = r_tvalid;
    w_done_nxt   = 1'b0;
    w_gap_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_SEND;
          w_init       = 1'b1;
          w_load       = 1'b1;
          w_first      = 1'b1;
          w_tvalid_nxt = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_hs && !r_tlast) begin
          w_load = 1'b1;
        end else if (w_hs) begin
          if (w_limit) begin
            w_state_nxt  = ST_IDLE;
            w_tvalid_nxt = 1'b0;
            w_done_nxt   = 1'b1;
          end else if (w_stop_any) begin
            w_state_nxt  = ST_IDLE;
            w_tvalid_nxt = 1'b0;
          end else if (r_gap != 8'd0) begin
            w_state_nxt  = ST_GAP;
            w_tvalid_nxt = 1'b0;
            w_gap_load   = 1'b1;
          end else begin
            w_load  = 1'b1;
            w_first = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt == 8'd1) begin
          w_state_nxt  = ST_SEND;
          w_load       = 1'b1;
          w_first      = 1'b1;
          w_tvalid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_mode      <= '0;
      r_const     <= '0;
      r_num_pkts  <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_beats     <= '0;
      r_beat_idx  <= '0;
      r_last_keep <= '0;
      r_ch        <= '0;
      r_stop_pend <= 1'b0;
      r_pkts_sent <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tdest     <= '0;
    end else begin
      r_tvalid <= w_tvalid_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_init) begin
        r_mode      <= cfg_mode;
        r_const     <= cfg_const;
        r_num_pkts  <= cfg_num_pkts;
        r_gap       <= cfg_gap;
        r_beats     <= w_cfg_beats;
        r_last_keep <= w_cfg_keep;
        r_pkts_sent <= '0;
        r_stop_pend <= 1'b0;
        r_ch        <= '0;
      end else begin
        if (r_state == ST_SEND) r_stop_pend <= w_stop_any && (w_state_nxt != ST_IDLE);
        if (w_last_hs) begin
          r_pkts_sent <= r_pkts_sent + 32'd1;
          r_ch        <= w_nch;
        end
      end
      if (w_load) begin
        r_tdata    <= w_beat_data;
        r_tkeep    <= w_last_nxt ? w_keep_sel : '1;
        r_tlast    <= w_last_nxt;
        r_tdest    <= w_src_ch;
        r_beat_idx <= w_idx_nxt;
      end
      if (w_gap_load)              r_gap_cnt <= r_gap;
      else if (r_state == ST_GAP)  r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  // Channel state is fully re-seeded by start, so it needs no reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (w_init) begin
        r_wcnt[c] <= '0;
        r_lfsr[c] <= 32'h1 + 32'(c);
      end else if (w_hs && (c == int'(r_ch))) begin
        r_wcnt[c] <= w_adv_w;
        r_lfsr[c] <= w_adv_lfsr;
      end
    end
  end

  assign tdata     = r_tdata;
  assign tkeep     = r_tkeep;
  assign tlast     = r_tlast;
  assign tdest     = r_tdest;
  assign tvalid    = r_tvalid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pkts_sent = r_pkts_sent;

endmodule
